// File: rtl/branch_predict_unit.sv
// Branch prediction unit: BHT/BTB lookup at fetch, outcome resolution,
// mispredict detection, table training and statistics at execute.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PC_W - IDX_W - 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  F_PC,
    output logic             F_PredTaken,
    output logic [31:0]      F_PredPC,
    input  logic             E_Valid,
    input  logic [PC_W-1:0]  E_PC,
    input  logic [31:0]      E_Imm,
    input  logic             E_Branch,
    input  logic             E_Jump,
    input  logic [31:0]      E_AluResult,
    input  logic             E_PredTaken,
    input  logic [31:0]      E_PredPC,
    output logic             E_Mispredict,
    output logic [31:0]      E_RedirectPC,
    output logic [31:0]      E_PC_Four,
    input  logic             Clr_Stats,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MissCount
);

    if (TAG_W < 1) begin : g_bad_tag
        $error("branch_predict_unit: PC_W too small for ENTRIES (TAG_W < 1)");
    end
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predict_unit: ENTRIES must be a power of two >= 2");
    end

    // Jump forces strongly taken; allocation starts weak; hits saturate.
    function automatic logic [1:0] next_cnt(input logic hit, input logic [1:0] cur,
                                            input logic taken, input logic jump);
        if (jump) begin
            return 2'b11;
        end else if (!hit) begin
            return taken ? 2'b10 : 2'b01;
        end else if (taken) begin
            return (cur == 2'b11) ? cur : cur + 2'd1;
        end else begin
            return (cur == 2'b00) ? cur : cur - 2'd1;
        end
    endfunction

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [31:0]       tgt_q   [ENTRIES];
    logic              jmp_q   [ENTRIES];
    logic [1:0]        cnt_q   [ENTRIES];
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  f_idx_s, e_idx_s;
    logic [TAG_W-1:0]  f_tag_s, e_tag_s;
    logic [31:0]       f_pc32_s, e_pc32_s, e_tgt_s;
    logic              f_hit_s, e_hit_s, e_act_taken_s, train_s, alias_s;
    logic              unused_alu_s;

    assign f_idx_s  = F_PC[IDX_W+1:2];
    assign f_tag_s  = F_PC[PC_W-1:IDX_W+2];
    assign e_idx_s  = E_PC[IDX_W+1:2];
    assign e_tag_s  = E_PC[PC_W-1:IDX_W+2];
    assign f_pc32_s = {{(32-PC_W){1'b0}}, F_PC};
    assign e_pc32_s = {{(32-PC_W){1'b0}}, E_PC};
    // Only the condition bit of the ALU result matters.
    assign unused_alu_s = ^E_AluResult[31:1];

    // Fetch-side lookup and execute-side resolution.
    always_comb begin
        f_hit_s       = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        F_PredTaken   = f_hit_s && (jmp_q[f_idx_s] || cnt_q[f_idx_s][1]);
        F_PredPC      = F_PredTaken ? tgt_q[f_idx_s] : f_pc32_s + 32'd4;
        e_hit_s       = valid_q[e_idx_s] && (tag_q[e_idx_s] == e_tag_s);
        e_act_taken_s = (E_Branch && E_AluResult[0]) || E_Jump;
        e_tgt_s       = e_pc32_s + E_Imm;
        E_PC_Four     = e_pc32_s + 32'd4;
        E_RedirectPC  = e_act_taken_s ? e_tgt_s : E_PC_Four;
        E_Mispredict  = E_Valid && ((e_act_taken_s != E_PredTaken) ||
                                    (e_act_taken_s && (E_PredPC != e_tgt_s)));
        train_s       = E_Valid && (E_Branch || E_Jump);
        // A non-branch predicted taken means a stale alias in the table.
        alias_s       = E_Valid && !(E_Branch || E_Jump) && E_PredTaken &&
                        (tag_q[e_idx_s] == e_tag_s);
    end

    // Saturating statistics next-state; clear has priority over counting.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (Clr_Stats) begin
            branch_cnt_d = {CNT_W{1'b0}};
            miss_cnt_d   = {CNT_W{1'b0}};
        end else begin
            if (train_s && !(&branch_cnt_q)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
            if (E_Mispredict && !(&miss_cnt_q)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end else begin
                miss_cnt_d = miss_cnt_q;
            end
        end
    end

    // BHT/BTB table update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= {TAG_W{1'b0}};
                tgt_q[i]   <= 32'd0;
                jmp_q[i]   <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (train_s) begin
            valid_q[e_idx_s] <= 1'b1;
            tag_q[e_idx_s]   <= e_tag_s;
            tgt_q[e_idx_s]   <= e_tgt_s;
            jmp_q[e_idx_s]   <= E_Jump;
            cnt_q[e_idx_s]   <= next_cnt(e_hit_s, cnt_q[e_idx_s], e_act_taken_s, E_Jump);
        end else if (alias_s) begin
            valid_q[e_idx_s] <= 1'b0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q <= {CNT_W{1'b0}};
            miss_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default config plus CNT_W=2).
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  F_PC;
    logic        F_PredTaken, F_PredTaken2;
    logic [31:0] F_PredPC, F_PredPC2;
    logic        E_Valid, E_Branch, E_Jump, E_PredTaken;
    logic [8:0]  E_PC;
    logic [31:0] E_Imm, E_AluResult, E_PredPC;
    logic        E_Mispredict, E_Mispredict2;
    logic [31:0] E_RedirectPC, E_RedirectPC2, E_PC_Four, E_PC_Four2;
    logic        Clr_Stats;
    logic [15:0] BranchCount, MissCount;
    logic [1:0]  BranchCount2, MissCount2;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_PredTaken(F_PredTaken), .F_PredPC(F_PredPC),
        .E_Valid(E_Valid), .E_PC(E_PC), .E_Imm(E_Imm), .E_Branch(E_Branch), .E_Jump(E_Jump),
        .E_AluResult(E_AluResult), .E_PredTaken(E_PredTaken), .E_PredPC(E_PredPC),
        .E_Mispredict(E_Mispredict), .E_RedirectPC(E_RedirectPC), .E_PC_Four(E_PC_Four),
        .Clr_Stats(Clr_Stats), .BranchCount(BranchCount), .MissCount(MissCount)
    );

    branch_predict_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_PredTaken(F_PredTaken2), .F_PredPC(F_PredPC2),
        .E_Valid(E_Valid), .E_PC(E_PC), .E_Imm(E_Imm), .E_Branch(E_Branch), .E_Jump(E_Jump),
        .E_AluResult(E_AluResult), .E_PredTaken(E_PredTaken), .E_PredPC(E_PredPC),
        .E_Mispredict(E_Mispredict2), .E_RedirectPC(E_RedirectPC2), .E_PC_Four(E_PC_Four2),
        .Clr_Stats(Clr_Stats), .BranchCount(BranchCount2), .MissCount(MissCount2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                         input logic br, input logic jmp, input logic alu,
                         input logic pt, input logic [31:0] ppc);
        E_Valid = v; E_PC = pc; E_Imm = imm; E_Branch = br; E_Jump = jmp;
        E_AluResult = {31'd0, alu}; E_PredTaken = pt; E_PredPC = ppc;
    endtask

    task automatic idle_e();
        set_e(1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; Clr_Stats = 1'b0; F_PC = 9'h000; idle_e();
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        F_PC = 9'h010; #1;
        tests_run++;
        if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL reset_pt got %b exp 0", F_PredTaken); end
        tests_run++;
        if (F_PredPC !== 32'h14) begin fails++; $display("FAIL reset_ppc got %h exp 14", F_PredPC); end
        tests_run++;
        if (BranchCount !== 16'd0 || MissCount !== 16'd0) begin
            fails++; $display("FAIL reset_stats got %0d/%0d exp 0/0", BranchCount, MissCount);
        end
        tests_run++;
        if (E_Mispredict !== 1'b0) begin fails++; $display("FAIL reset_mis got %b exp 0", E_Mispredict); end
        F_PC = 9'h1FC; #1;
        tests_run++;
        if (F_PredPC !== 32'h200) begin fails++; $display("FAIL fpc_carry got %h exp 200", F_PredPC); end
    endtask

    task automatic test_taken_train();
        do_reset();
        set_e(1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h24); #1;
        tests_run++;
        if (E_Mispredict !== 1'b1 || E_RedirectPC !== 32'h60) begin
            fails++; $display("FAIL taken_mis got %b/%h exp 1/60", E_Mispredict, E_RedirectPC);
        end
        tests_run++;
        if (E_PC_Four !== 32'h24) begin fails++; $display("FAIL pc_four got %h exp 24", E_PC_Four); end
        step();
        idle_e(); F_PC = 9'h020; #1;
        tests_run++;
        if (F_PredTaken !== 1'b1 || F_PredPC !== 32'h60) begin
            fails++; $display("FAIL taken_pred got %b/%h exp 1/60", F_PredTaken, F_PredPC);
        end
        tests_run++;
        if (BranchCount !== 16'd1 || MissCount !== 16'd1) begin
            fails++; $display("FAIL taken_stats got %0d/%0d exp 1/1", BranchCount, MissCount);
        end
    endtask

    task automatic test_counter();
        logic alu_v [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic pt_v  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic mis_v [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic fpt_v [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_rd;
        do_reset();
        F_PC = 9'h020;
        for (int i = 0; i < 8; i++) begin
            set_e(1'b1, 9'h020, 32'h40, 1'b1, 1'b0, alu_v[i], pt_v[i], pt_v[i] ? 32'h60 : 32'h24);
            exp_rd = alu_v[i] ? 32'h60 : 32'h24;
            #1;
            tests_run++;
            if (E_Mispredict !== mis_v[i] || E_RedirectPC !== exp_rd) begin
                fails++; $display("FAIL cnt_mis[%0d] got %b/%h exp %b/%h", i, E_Mispredict, E_RedirectPC, mis_v[i], exp_rd);
            end
            step();
            idle_e(); #1;
            tests_run++;
            if (F_PredTaken !== fpt_v[i]) begin
                fails++; $display("FAIL cnt_pred[%0d] got %b exp %b", i, F_PredTaken, fpt_v[i]);
            end
        end
        tests_run++;
        if (BranchCount !== 16'd8 || MissCount !== 16'd5) begin
            fails++; $display("FAIL cnt_stats got %0d/%0d exp 8/5", BranchCount, MissCount);
        end
    endtask

    task automatic test_jump();
        do_reset();
        set_e(1'b1, 9'h040, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44); #1;
        tests_run++;
        if (E_Mispredict !== 1'b1 || E_RedirectPC !== 32'h140) begin
            fails++; $display("FAIL jump_mis got %b/%h exp 1/140", E_Mispredict, E_RedirectPC);
        end
        step();
        idle_e(); F_PC = 9'h040; #1;
        tests_run++;
        if (F_PredTaken !== 1'b1 || F_PredPC !== 32'h140) begin
            fails++; $display("FAIL jump_pred got %b/%h exp 1/140", F_PredTaken, F_PredPC);
        end
        set_e(1'b1, 9'h040, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h140); #1;
        tests_run++;
        if (E_Mispredict !== 1'b0) begin fails++; $display("FAIL jump_hit got %b exp 0", E_Mispredict); end
        set_e(1'b1, 9'h040, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h144); #1;
        tests_run++;
        if (E_Mispredict !== 1'b1 || E_RedirectPC !== 32'h140) begin
            fails++; $display("FAIL jump_tgt got %b/%h exp 1/140", E_Mispredict, E_RedirectPC);
        end
        set_e(1'b1, 9'h010, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h14); #1;
        tests_run++;
        if (E_RedirectPC !== 32'h0) begin fails++; $display("FAIL jump_wrap got %h exp 0", E_RedirectPC); end
        idle_e();
    endtask

    task automatic test_alias();
        do_reset();
        F_PC = 9'h020;
        set_e(1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h24); step();
        set_e(1'b1, 9'h060, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h64); #1;
        tests_run++;
        if (E_Mispredict !== 1'b0) begin fails++; $display("FAIL alias_nopt got %b exp 0", E_Mispredict); end
        step();
        set_e(1'b1, 9'h060, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60); #1;
        tests_run++;
        if (E_Mispredict !== 1'b1 || E_RedirectPC !== 32'h64) begin
            fails++; $display("FAIL alias_diff got %b/%h exp 1/64", E_Mispredict, E_RedirectPC);
        end
        step();
        idle_e(); #1;
        tests_run++;
        if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL alias_keep got %b exp 1", F_PredTaken); end
        set_e(1'b1, 9'h020, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60); #1;
        tests_run++;
        if (E_Mispredict !== 1'b1 || E_RedirectPC !== 32'h24) begin
            fails++; $display("FAIL alias_same got %b/%h exp 1/24", E_Mispredict, E_RedirectPC);
        end
        step();
        idle_e(); #1;
        tests_run++;
        if (F_PredTaken !== 1'b0 || F_PredPC !== 32'h24) begin
            fails++; $display("FAIL alias_inval got %b/%h exp 0/24", F_PredTaken, F_PredPC);
        end
        tests_run++;
        if (BranchCount !== 16'd1 || MissCount !== 16'd3) begin
            fails++; $display("FAIL alias_stats got %0d/%0d exp 1/3", BranchCount, MissCount);
        end
    endtask

    task automatic test_collision();
        do_reset();
        F_PC = 9'h030;
        set_e(1'b1, 9'h030, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h34); #1;
        tests_run++;
        if (F_PredTaken !== 1'b0 || F_PredPC !== 32'h34) begin
            fails++; $display("FAIL coll_old got %b/%h exp 0/34", F_PredTaken, F_PredPC);
        end
        step();
        idle_e(); #1;
        tests_run++;
        if (F_PredTaken !== 1'b1 || F_PredPC !== 32'h40) begin
            fails++; $display("FAIL coll_new got %b/%h exp 1/40", F_PredTaken, F_PredPC);
        end
    endtask

    task automatic test_invalid_and_mid_reset();
        do_reset();
        F_PC = 9'h050;
        set_e(1'b0, 9'h050, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h54); #1;
        tests_run++;
        if (E_Mispredict !== 1'b0) begin fails++; $display("FAIL inv_mis got %b exp 0", E_Mispredict); end
        step();
        idle_e(); #1;
        tests_run++;
        if (F_PredTaken !== 1'b0 || BranchCount !== 16'd0 || MissCount !== 16'd0) begin
            fails++; $display("FAIL inv_state got %b/%0d/%0d exp 0/0/0", F_PredTaken, BranchCount, MissCount);
        end
        set_e(1'b1, 9'h030, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h34); step();
        set_e(1'b1, 9'h070, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h74);
        reset = 1'b1; step();
        reset = 1'b0; idle_e(); F_PC = 9'h070; #1;
        tests_run++;
        if (F_PredTaken !== 1'b0 || F_PredPC !== 32'h74) begin
            fails++; $display("FAIL mid_reset got %b/%h exp 0/74", F_PredTaken, F_PredPC);
        end
        F_PC = 9'h030; #1;
        tests_run++;
        if (F_PredTaken !== 1'b0 || BranchCount !== 16'd0) begin
            fails++; $display("FAIL mid_reset_old got %b/%0d exp 0/0", F_PredTaken, BranchCount);
        end
    endtask

    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_e(1'b1, 9'h080, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h84);
            step();
        end
        idle_e(); #1;
        tests_run++;
        if (BranchCount !== 16'd4 || MissCount !== 16'd4) begin
            fails++; $display("FAIL stats_wide got %0d/%0d exp 4/4", BranchCount, MissCount);
        end
        tests_run++;
        if (BranchCount2 !== 2'd3 || MissCount2 !== 2'd3) begin
            fails++; $display("FAIL stats_sat got %0d/%0d exp 3/3", BranchCount2, MissCount2);
        end
        set_e(1'b1, 9'h0C0, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC4);
        Clr_Stats = 1'b1; step();
        Clr_Stats = 1'b0; idle_e(); #1;
        tests_run++;
        if (MissCount !== 16'd0 || BranchCount !== 16'd0 || MissCount2 !== 2'd0) begin
            fails++; $display("FAIL stats_clr got %0d/%0d/%0d exp 0/0/0", MissCount, BranchCount, MissCount2);
        end
    endtask

    initial begin
        test_reset();
        test_taken_train();
        test_counter();
        test_jump();
        test_alias();
        test_collision();
        test_invalid_and_mid_reset();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
